// File: rtl/othello_pkg.sv
// rtl/othello_pkg.sv - shared Othello cell encoding, board address width and move_entry states
package othello_pkg;

  localparam int ADDR_W = 6;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_BLACK = 2'b01;
  localparam logic [1:0] CELL_WHITE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_CHECK = 2'd2,
    ST_REQ   = 2'd3
  } move_state_e;

  function automatic logic [1:0] piece_for(input logic side);
    return side ? CELL_WHITE : CELL_BLACK;
  endfunction

endpackage

// File: rtl/move_entry.sv
// rtl/move_entry.sv - turns a cursor enter strobe into a committed Othello move
// Reads the target cell, writes the mover's piece if empty, then hands off to the flip engine.
module move_entry
  import othello_pkg::*;
#(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic              clk,
  input  logic              RST,
  input  logic [2:0]        X,
  input  logic [2:0]        Y,
  input  logic              enter,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [1:0]        wr_data,
  output logic              move_req,
  input  logic              move_ack,
  output logic [2:0]        move_x,
  output logic [2:0]        move_y,
  output logic              player,
  output logic              busy,
  output logic              move_done,
  output logic              move_reject
);

  move_state_e       state_q, state_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [1:0]        wr_data_q, wr_data_d;
  logic [2:0]        move_x_q, move_x_d;
  logic [2:0]        move_y_q, move_y_d;
  logic              wr_en_q, wr_en_d;
  logic              move_req_q, move_req_d;
  logic              player_q, player_d;
  logic              busy_q, busy_d;
  logic              move_done_q, move_done_d;
  logic              move_reject_q, move_reject_d;

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q       <= ST_IDLE;
      rd_addr_q     <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      move_x_q      <= '0;
      move_y_q      <= '0;
      wr_en_q       <= 1'b0;
      move_req_q    <= 1'b0;
      player_q      <= FIRST_PLAYER;
      busy_q        <= 1'b0;
      move_done_q   <= 1'b0;
      move_reject_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_addr_q     <= rd_addr_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      move_x_q      <= move_x_d;
      move_y_q      <= move_y_d;
      wr_en_q       <= wr_en_d;
      move_req_q    <= move_req_d;
      player_q      <= player_d;
      busy_q        <= busy_d;
      move_done_q   <= move_done_d;
      move_reject_q <= move_reject_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (enter) state_d = ST_READ;
      ST_READ:  state_d = ST_CHECK;
      ST_CHECK: state_d = (rd_data == CELL_EMPTY) ? ST_REQ : ST_IDLE;
      ST_REQ:   if (move_ack) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs; busy is computed from the next state
  // so it rises on the same edge that samples enter.
  always_comb begin
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    move_x_d      = move_x_q;
    move_y_d      = move_y_q;
    player_d      = player_q;
    move_req_d    = move_req_q;
    wr_en_d       = 1'b0;
    move_done_d   = 1'b0;
    move_reject_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enter) begin
          move_x_d  = X;
          move_y_d  = Y;
          rd_addr_d = {Y, X};
        end
      end
      ST_CHECK: begin
        if (rd_data == CELL_EMPTY) begin
          wr_en_d   = 1'b1;
          wr_addr_d = {move_y_q, move_x_q};
          wr_data_d = piece_for(player_q);
        end else begin
          move_reject_d = 1'b1;
        end
      end
      ST_REQ: begin
        if (move_ack) begin
          move_req_d  = 1'b0;
          player_d    = ~player_q;
          move_done_d = 1'b1;
        end else begin
          move_req_d  = 1'b1;
        end
      end
      default: ;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  assign rd_addr     = rd_addr_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign move_x      = move_x_q;
  assign move_y      = move_y_q;
  assign wr_en       = wr_en_q;
  assign move_req    = move_req_q;
  assign player      = player_q;
  assign busy        = busy_q;
  assign move_done   = move_done_q;
  assign move_reject = move_reject_q;

endmodule

// File: tb/tb_move_entry.sv
// tb/tb_move_entry.sv - randomized self-checking bench for move_entry against a board/player model
module tb_move_entry;

  logic       clk = 1'b0;
  logic       RST;
  logic [2:0] X, Y;
  logic       enter;
  logic [5:0] rd_addr;
  logic [1:0] rd_data;
  logic       wr_en;
  logic [5:0] wr_addr;
  logic [1:0] wr_data;
  logic       move_req;
  logic       move_ack;
  logic [2:0] move_x, move_y;
  logic       player;
  logic       busy;
  logic       move_done;
  logic       move_reject;

  move_entry #(.FIRST_PLAYER(1'b0)) dut (
    .clk(clk), .RST(RST), .X(X), .Y(Y), .enter(enter),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .move_req(move_req), .move_ack(move_ack),
    .move_x(move_x), .move_y(move_y), .player(player), .busy(busy),
    .move_done(move_done), .move_reject(move_reject)
  );

  always #5 clk = ~clk;

  // Board RAM with one-cycle synchronous read; contents maintained by the bench.
  logic [1:0] ram [64];
  always @(posedge clk) rd_data <= ram[rd_addr];

  // Reference model: the board as the game sees it, and whose turn it is.
  logic [1:0] ref_board [64];
  logic       ref_player;

  int checks = 0;
  int failures = 0;

  // {busy, wr_en, move_req, move_done, move_reject}
  wire [4:0]  flags = {busy, wr_en, move_req, move_done, move_reject};
  wire [19:0] addr_regs = {rd_addr, wr_addr, wr_data, move_y, move_x};

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [5:0] pick_empty();
    logic [5:0] a;
    for (int t = 0; t < 200; t++) begin
      a = 6'($urandom);
      if (ref_board[a] == 2'b00) return a;
    end
    for (int i = 0; i < 64; i++) if (ref_board[i] == 2'b00) return 6'(i);
    return 6'd0;
  endfunction

  // One press at cell a; ack_wait=0 means ack is already high on the first REQ cycle,
  // otherwise ack arrives ack_wait cycles after move_req rises.
  task automatic exercise_move(input logic [5:0] a, input int ack_wait, input bit strays);
    logic       occ;
    logic [1:0] piece;
    logic       old_player;
    occ        = (ref_board[a] != 2'b00);
    piece      = ref_player ? 2'b10 : 2'b01;
    old_player = ref_player;
    X = a[2:0]; Y = a[5:3]; enter = 1'b1;
    step;  // E0
    enter = 1'b0; X = 3'($urandom); Y = 3'($urandom);
    if (ack_wait > 0) move_ack = 1'($urandom);
    checks++; if (flags !== 5'b10000) begin failures++; $display("FAIL e0_flags act=%b exp=%b", flags, 5'b10000); end
    checks++; if (rd_addr !== a) begin failures++; $display("FAIL e0_rd_addr act=%o exp=%o", rd_addr, a); end
    checks++; if ({move_y, move_x} !== a) begin failures++; $display("FAIL e0_move_xy act=%o exp=%o", {move_y, move_x}, a); end
    step;  // E1
    checks++; if (flags !== 5'b10000) begin failures++; $display("FAIL e1_flags act=%b exp=%b", flags, 5'b10000); end
    step;  // E2
    if (ack_wait > 0) move_ack = 1'b0;
    if (occ) begin
      checks++; if (flags !== 5'b00001) begin failures++; $display("FAIL reject_flags act=%b exp=%b", flags, 5'b00001); end
      checks++; if (player !== ref_player) begin failures++; $display("FAIL reject_player act=%b exp=%b", player, ref_player); end
      return;
    end
    checks++; if (flags !== 5'b11000) begin failures++; $display("FAIL write_flags act=%b exp=%b", flags, 5'b11000); end
    checks++; if (wr_addr !== a) begin failures++; $display("FAIL wr_addr act=%o exp=%o", wr_addr, a); end
    checks++; if (wr_data !== piece) begin failures++; $display("FAIL wr_data act=%b exp=%b", wr_data, piece); end
    ram[a] = piece;
    ref_board[a] = piece;
    if (ack_wait == 0) begin
      move_ack = 1'b1;
    end else begin
      step;  // E3
      checks++; if (flags !== 5'b10100) begin failures++; $display("FAIL req_flags act=%b exp=%b", flags, 5'b10100); end
      for (int i = 1; i < ack_wait; i++) begin
        if (strays) begin
          enter = (i == 2) ? 1'b1 : 1'($urandom);
          X = 3'($urandom); Y = 3'($urandom);
        end
        step;
        enter = 1'b0;
        checks++; if (flags !== 5'b10100) begin failures++; $display("FAIL hold_flags cyc=%0d act=%b exp=%b", i, flags, 5'b10100); end
        checks++; if (rd_addr !== a || player !== ref_player) begin failures++; $display("FAIL hold_addr_player cyc=%0d act=%o/%b exp=%o/%b", i, rd_addr, player, a, ref_player); end
      end
      move_ack = 1'b1;
    end
    step;  // handshake edge
    move_ack = 1'b0;
    ref_player = ~ref_player;
    checks++; if (flags !== 5'b00010) begin failures++; $display("FAIL done_flags act=%b exp=%b", flags, 5'b00010); end
    checks++; if (player !== ref_player || player === old_player) begin failures++; $display("FAIL done_player act=%b exp=%b", player, ref_player); end
  endtask

  task automatic test_reset;
    RST = 1'b1;
    repeat (3) step;
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL reset_flags act=%b exp=%b", flags, 5'b00000); end
    checks++; if (addr_regs !== 20'h0) begin failures++; $display("FAIL reset_regs act=%h exp=%h", addr_regs, 20'h0); end
    checks++; if (player !== 1'b0) begin failures++; $display("FAIL reset_player act=%b exp=%b", player, 1'b0); end
    #3 RST = 1'b0;
    ref_player = 1'b0;
    step;
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL post_reset_flags act=%b exp=%b", flags, 5'b00000); end
  endtask

  task automatic test_accept;
    exercise_move(6'o43, 2, 1'b0);
    step;
    checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL accept_idle act=%b exp=%b", flags, 5'b00000); end
    for (int n = 0; n < 6; n++) begin
      exercise_move(pick_empty(), int'($urandom_range(0, 3)), 1'b0);
      repeat ($urandom_range(1, 3)) step;
    end
  endtask

  task automatic test_reject;
    logic [5:0] a;
    for (int n = 0; n < 3; n++) begin
      a = (n == 0) ? 6'o00 : pick_empty();
      ref_board[a] = (n == 0) ? 2'b10 : 2'($urandom_range(1, 3));
      ram[a] = ref_board[a];
      exercise_move(a, 1, 1'b0);
      // A fresh enter on the very next edge must be accepted.
      exercise_move(pick_empty(), 0, 1'b0);
      step;
    end
  endtask

  task automatic test_ack_withheld;
    exercise_move(pick_empty(), 21, 1'b1);
    step;
  endtask

  task automatic test_ack_high;
    logic p;
    p = ref_player;
    move_ack = 1'b1;
    repeat (4) step;
    checks++; if (flags !== 5'b00000 || player !== p) begin failures++; $display("FAIL idle_ack act=%b/%b exp=%b/%b", flags, player, 5'b00000, p); end
    exercise_move(pick_empty(), 0, 1'b0);
    step;
  endtask

  task automatic test_async_reset;
    logic [5:0] a;
    // Abort while in CHECK.
    a = pick_empty();
    X = a[2:0]; Y = a[5:3]; enter = 1'b1;
    step; enter = 1'b0;
    step;
    #2 RST = 1'b1;
    #1;
    ref_player = 1'b0;
    checks++; if (flags !== 5'b00000 || addr_regs !== 20'h0) begin failures++; $display("FAIL rst_check act=%b/%h exp=%b/%h", flags, addr_regs, 5'b00000, 20'h0); end
    @(posedge clk); #3 RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step;
      checks++; if (flags !== 5'b00000) begin failures++; $display("FAIL rst_check_after cyc=%0d act=%b exp=%b", i, flags, 5'b00000); end
    end
    // Give the turn to white, then abort while waiting in REQ.
    exercise_move(pick_empty(), 0, 1'b0);
    step;
    a = pick_empty();
    X = a[2:0]; Y = a[5:3]; enter = 1'b1;
    step; enter = 1'b0;
    step; step;
    ram[a] = 2'b10;
    ref_board[a] = 2'b10;
    step;
    checks++; if (move_req !== 1'b1 || player !== 1'b1) begin failures++; $display("FAIL pre_rst_req act=%b/%b exp=1/1", move_req, player); end
    #2 RST = 1'b1;
    #1;
    ref_player = 1'b0;
    checks++; if (flags !== 5'b00000 || player !== 1'b0) begin failures++; $display("FAIL rst_req act=%b/%b exp=%b/0", flags, player, 5'b00000); end
    @(posedge clk); #3 RST = 1'b0;
    move_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step;
      checks++; if (flags !== 5'b00000 || player !== 1'b0) begin failures++; $display("FAIL rst_req_after cyc=%0d act=%b/%b exp=%b/0", i, flags, player, 5'b00000); end
    end
    move_ack = 1'b0;
  endtask

  task automatic test_back_to_back;
    checks++; if (player !== 1'b0) begin failures++; $display("FAIL b2b_start_player act=%b exp=0", player); end
    exercise_move(pick_empty(), 0, 1'b0);
    exercise_move(pick_empty(), int'($urandom_range(1, 2)), 1'b0);
    checks++; if (player !== 1'b0) begin failures++; $display("FAIL b2b_end_player act=%b exp=0", player); end
    step;
  endtask

  initial begin
    RST = 1'b1; enter = 1'b0; X = '0; Y = '0; move_ack = 1'b0;
    for (int i = 0; i < 64; i++) begin
      ram[i] = 2'b00;
      ref_board[i] = 2'b00;
    end
    ref_player = 1'b0;
    test_reset;
    test_accept;
    test_reject;
    test_ack_withheld;
    test_ack_high;
    test_async_reset;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

endmodule

// File: doc/move_entry.md
# move_entry

Consumes the cursor position and one-cycle `enter` strobe produced by the cursor/button block and turns each press into a committed Othello move. On `enter` it reads the addressed cell from the board RAM. If the cell is empty, it writes the current player's piece and hands the move to the downstream flip engine over a req/ack handshake. If the cell is occupied, it rejects the move. It also owns the current-player register.

## Interface
Parameters:
- `FIRST_PLAYER`, default 0: player after reset (0 = black, 1 = white).

Ports:
- `clk`  in  1  system clock, rising edge.
- `RST`  in  1  reset; one clock; asynchronous, active-high.
- `X`  in  3  cursor column from the cursor block.
- `Y`  in  3  cursor row from the cursor block.
- `enter`  in  1  one-cycle move strobe from the cursor block.
- `rd_addr`  out  6  board RAM read address `{Y,X}`.
- `rd_data`  in  2  board RAM read data; synchronous, 1-cycle latency.
- `wr_en`  out  1  board RAM write strobe, one cycle.
- `wr_addr`  out  6  board RAM write address.
- `wr_data`  out  2  cell value to write.
- `move_req`  out  1  move available to the flip engine.
- `move_ack`  in  1  flip engine accepted the move.
- `move_x`  out  3  latched column of the move in progress.
- `move_y`  out  3  latched row of the move in progress.
- `player`  out  1  side to move.
- `busy`  out  1  high in every state except IDLE.
- `move_done`  out  1  one-cycle pulse when a move is accepted.
- `move_reject`  out  1  one-cycle pulse when the target cell is occupied.

## Operation
- Cell encoding: EMPTY=2'b00, BLACK=2'b01, WHITE=2'b10, 2'b11 reserved.
  - 2'b11 is treated as occupied.
- Piece written is BLACK when `player`=0 and WHITE when `player`=1.
- Addresses are formed as `{Y,X}` with no arithmetic, so there is no wrap concern.
- All outputs are registered.
- FSM states: IDLE, READ, CHECK, REQ.
  - **IDLE**:
    - Action when `enter`=1: latch `move_x`/`move_y` from `X`/`Y`, drive `rd_addr`<={Y,X}, go to READ.
    - `enter`=0: stay in IDLE.
  - **READ**: unconditionally go to CHECK. `rd_data` is valid during CHECK.
  - **CHECK**, when `rd_data`==EMPTY:
    - assert `wr_en`=1 for one cycle;
    - drive `wr_addr`={move_y,move_x} and `wr_data`=piece;
    - go to REQ.
  - **CHECK**, otherwise: pulse `move_reject`, go to IDLE.
  - **REQ**:
    - deassert `wr_en`; `move_req`=1 from the first cycle after the write and held.
    - When `move_ack` is sampled 1: `move_req`<=0, `player`<=~`player`, pulse `move_done`, go to IDLE.
- `enter` outside IDLE is ignored and not queued.
- `X`/`Y` changes after the latch do not affect the move in progress.
- `move_ack` outside REQ is ignored.
- A `move_ack` already high on the first REQ cycle completes the handshake on that edge.

## Timing
- Reset values: state IDLE; `player`=FIRST_PLAYER; every other output 0.
- Reset is asynchronous. Asserting `RST` in any state aborts immediately: no write, no pulse, `move_req` drops.
- Enter sampled at edge E0:
  - `busy`=1 from E0;
  - `move_reject` or `wr_en` high in the cycle after E2;
  - `move_req` high after E3.
- Minimum accepted-move latency, from `enter` edge to `move_done`, is 4 edges (ack already high).
- `move_reject` path: back in IDLE after E2, so a new `enter` is accepted at E3.
- `move_done` and `player` toggle occur on the same edge. `player` is stable at all other times.

## Structure
- Shared package `othello_pkg` holds:
  - cell constants EMPTY/BLACK/WHITE;
  - the 6-bit board address width;
  - the move_entry FSM state enum.
- Single module; no sub-module is needed.
- The edge/ack logic is small enough to inline.

## Test plan
- Reset, `FIRST_PLAYER`=0, `rd_data`=00, `enter` at X=3,Y=4 → `rd_addr`=6'o43; `wr_en` one cycle after E2 with `wr_addr`=6'o43 and `wr_data`=01; `move_req`; ack → `move_done`, `player`=1.
- `rd_data`=10 at X=0,Y=0 → `move_reject` pulse after E2, no `wr_en`, `player` unchanged, `busy` low after E2.
- Withhold `move_ack` for 20 cycles → `move_req` held, `busy`=1, `player` unchanged; second `enter` in that window ignored (no new `rd_addr`).
- `move_ack` held permanently high → `move_done` exactly 4 edges after `enter`; `move_ack` pulsed in IDLE → no effect.
- Assert `RST` asynchronously in CHECK and again in REQ → outputs 0 immediately, `player`=FIRST_PLAYER, no write or pulse after release.
- Two accepted moves back to back → `wr_data` 01 then 10, `player` 0→1→0.
